// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch
// Description : Direct-mapped instruction cache placed in front of the CPU
//               fetch stage. Returns the instruction combinationally on a
//               hit and stalls the CPU (pc_en low) while a missing line is
//               burst-filled from a variable-latency instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        pc_en,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFFW = $clog2(WORDS);
  localparam int IDXW = $clog2(LINES);
  localparam int LOW  = OFFW + 2;          // first index bit of a byte address
  localparam int TAGW = 32 - LOW - IDXW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [LINES-1:0] valid_q,    valid_d;
  logic             mem_req_q,  mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [OFFW-1:0]  cnt_q,      cnt_d;
  logic             flushed_q,  flushed_d;
  logic [31:0]      hit_cnt_q,  hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  logic [OFFW-1:0]  w_lk_off;
  logic [IDXW-1:0]  w_lk_idx;
  logic [TAGW-1:0]  w_lk_tag;
  logic [IDXW-1:0]  w_fill_idx;
  logic [TAGW-1:0]  w_fill_tag;
  logic             w_hit;
  logic             w_beat;
  logic             w_last;
  logic             w_unused_pc;

  // Lookup fields come from the live pc; the fill line is identified by the
  // latched request address, so pc redirects mid-fill cannot disturb it.
  assign w_lk_off    = pc[LOW-1:2];
  assign w_lk_idx    = pc[LOW +: IDXW];
  assign w_lk_tag    = pc[31 -: TAGW];
  assign w_fill_idx  = mem_addr_q[LOW +: IDXW];
  assign w_fill_tag  = mem_addr_q[31 -: TAGW];
  assign w_unused_pc = ^pc[1:0];

  assign w_hit  = !reset && (state_q == IDLE) && valid_q[w_lk_idx] &&
                  (tag_q[w_lk_idx] == w_lk_tag);
  assign w_beat = (state_q == FILL) && mem_rvalid;
  assign w_last = w_beat && (cnt_q == OFFW'(WORDS - 1));

  assign inst     = w_hit ? data_q[{w_lk_idx, w_lk_off}] : 32'h0000_0000;
  assign pc_en    = w_hit;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Next-state logic: lookup / request / fill sequencing, valid bits, counters.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q | flush;
    valid_d    = flush ? '0 : valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (w_hit) begin
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc[31:LOW], {LOW{1'b0}}};
          flushed_d  = 1'b0;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      FILL: begin
        if (w_beat) cnt_d = cnt_q + 1'b1;
        if (w_last) begin
          state_d = IDLE;
          // A flush seen at any point of this fill (including now) wins.
          if (!flushed_q && !flush) valid_d[w_fill_idx] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: synchronous reset aborts any fill in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/data arrays: not reset, written only by fill beats outside reset.
  always_ff @(posedge clk) begin
    if (!reset && w_beat) data_q[{w_fill_idx, cnt_q}] <= mem_rdata;
    if (!reset && w_last) tag_q[w_fill_idx] <= w_fill_tag;
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch
// Description : Self-checking bench for icache_fetch with a hit scoreboard
//               and a scripted instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        pc_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          checks = 0;
  int          errors = 0;
  int          stall;
  int          reqcyc;
  int          exp_hit;
  int          exp_miss;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  icache_fetch #(.LINES(16), .WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .flush      (flush),
    .inst       (inst),
    .pc_en      (pc_en),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents: line 0 holds 0x11,0x22,0x33,0x44; elsewhere address-tagged.
  function automatic logic [31:0] model(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h10) return 32'h11 * ((w >> 2) + 32'd1);
    return {16'hC0DE, w[15:0]};
  endfunction

  // Scoreboard consumer: every cycle the DUT reports a hit must match the
  // next expected instruction.
  always @(negedge clk) begin
    if (pc_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit pc=%h got pc_en=1 inst=%h required pc_en=0", pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst !== mon_e) begin
          errors++;
          $display("FAIL hit_data pc=%h got %h required %h", pc, inst, mon_e);
        end
      end
    end
  end

  // Stimulus: hold pc for one cycle, expecting a hit.
  task automatic drive_hit(input logic [31:0] a);
    pc = a;
    exp_q.push_back(model(a));
    exp_hit++;
    @(posedge clk); #1;
  endtask

  // Memory responder: waits for the request, grants after gdly cycles,
  // returns beats separated by gap idle cycles. Optional pc redirect at beat
  // 1, flush pulse at beat flush_at, reset at beat abort_at.
  task automatic mem_serve(input logic [31:0] base, input int gdly, input int gap,
                           input logic [31:0] redir, input int flush_at,
                           input int abort_at);
    int n;
    n = 0;
    @(negedge clk);
    while (mem_req !== 1'b1 && n < 40) begin
      if (pc_en === 1'b0) stall++;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout got mem_req=%b required 1 base=%h", mem_req, base);
      return;
    end
    for (int d = 0; d <= gdly; d++) begin
      if (pc_en === 1'b0) stall++;
      if (mem_req === 1'b1) reqcyc++;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== base) begin
        errors++;
        $display("FAIL req_addr got req=%b addr=%h required req=1 addr=%h", mem_req, mem_addr, base);
      end
      if (d == gdly) mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      flush   = 1'b0;
      if (d < gdly) @(negedge clk);
    end
    for (int i = 0; i < WORDS; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (pc_en === 1'b0) stall++;
        @(posedge clk); #1;
      end
      if (i == abort_at) begin
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b0 || inst !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs got pc_en=%b inst=%h required 0 0", pc_en, inst);
        end
        @(posedge clk); #1;
        return;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = model(base + 32'(4 * i));
      if (i == 1 && redir != 32'h0) pc = redir;
      flush = (i == flush_at);
      @(negedge clk);
      if (pc_en === 1'b0) stall++;
      if (i == 0) begin
        checks++;
        if (mem_req !== 1'b0 || inst !== 32'h0) begin
          errors++;
          $display("FAIL fill_outputs got req=%b inst=%h required 0 0", mem_req, inst);
        end
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      flush      = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; pc = 32'h0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_hit = 0; exp_miss = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL rst_fetch got pc_en=%b inst=%h required 0 0", pc_en, inst);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mem got req=%b addr=%h required 0 0", mem_req, mem_addr);
    end
    checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_cnt got hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    stall = 0; reqcyc = 0;
    pc = 32'h0; exp_miss++;
    mem_serve(32'h0, 0, 0, 32'h0, -1, -1);
    checks++;
    if (stall !== 6) begin
      errors++; $display("FAIL cold_stall got %0d cycles required 6", stall);
    end
    checks++;
    if (reqcyc !== 1) begin
      errors++; $display("FAIL cold_req_cycles got %0d required 1", reqcyc);
    end
    drive_hit(32'h0);
    drive_hit(32'hC);
    checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'(exp_hit)) begin
      errors++; $display("FAIL cold_cnt got hit=%0d miss=%0d required %0d 1", hit_cnt, miss_cnt, exp_hit);
    end
  endtask

  task automatic test_conflict;
    stall = 0;
    pc = 32'h100; exp_miss++;
    mem_serve(32'h100, 0, 0, 32'h0, -1, -1);
    checks++;
    if (stall !== 6) begin
      errors++; $display("FAIL conflict_stall got %0d required 6", stall);
    end
    drive_hit(32'h104);
    drive_hit(32'h10C);
    pc = 32'h0; exp_miss++;
    mem_serve(32'h0, 0, 0, 32'h0, -1, -1);
    drive_hit(32'h8);
    checks++;
    if (miss_cnt !== 32'd3) begin
      errors++; $display("FAIL conflict_miss_cnt got %0d required 3", miss_cnt);
    end
  endtask

  task automatic test_stalled;
    stall = 0; reqcyc = 0;
    pc = 32'h24; exp_miss++;
    mem_serve(32'h20, 3, 2, 32'h0, -1, -1);
    checks++;
    if (stall !== 17 || reqcyc !== 4) begin
      errors++; $display("FAIL stalled_timing got stall=%0d req=%0d required 17 4", stall, reqcyc);
    end
    drive_hit(32'h24);
    drive_hit(32'h20);
    drive_hit(32'h28);
    drive_hit(32'h2C);
    drive_hit(32'h4);
  endtask

  task automatic test_redirect;
    pc = 32'h40; exp_miss++;
    mem_serve(32'h40, 0, 1, 32'h80, -1, -1);
    stall = 0; exp_miss++;
    mem_serve(32'h80, 0, 0, 32'h0, -1, -1);
    checks++;
    if (stall !== 6) begin
      errors++; $display("FAIL redirect_stall got %0d required 6", stall);
    end
    drive_hit(32'h84);
    drive_hit(32'h40);
    drive_hit(32'h4C);
    checks++;
    if (miss_cnt !== 32'(exp_miss) || hit_cnt !== 32'(exp_hit)) begin
      errors++; $display("FAIL redirect_cnt got hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_flush;
    drive_hit(32'h0);
    pc = 32'hF0; flush = 1'b1; exp_miss++;
    mem_serve(32'hF0, 0, 0, 32'h0, -1, -1);
    stall = 0;
    pc = 32'h0; exp_miss++;
    mem_serve(32'h0, 0, 0, 32'h0, 2, -1);
    checks++;
    if (stall !== 6) begin
      errors++; $display("FAIL flush_idle_stall got %0d required 6", stall);
    end
    stall = 0; exp_miss++;
    mem_serve(32'h0, 0, 0, 32'h0, -1, -1);
    checks++;
    if (stall !== 6) begin
      errors++; $display("FAIL flush_fill_stall got %0d required 6", stall);
    end
    drive_hit(32'h4);
    checks++;
    if (miss_cnt !== 32'(exp_miss)) begin
      errors++; $display("FAIL flush_miss_cnt got %0d required %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_reset_midfill;
    pc = 32'h44; exp_miss++;
    mem_serve(32'h40, 0, 0, 32'h0, -1, 2);
    exp_hit = 0; exp_miss = 0;
    checks++;
    if (mem_req !== 1'b0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++; $display("FAIL midfill_reset got req=%b hit=%0d miss=%0d required 0 0 0", mem_req, hit_cnt, miss_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_lookup got pc_en=%b required 0", pc_en);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    exp_miss++;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL post_reset_req got req=%b addr=%h miss=%0d required 1 00000040 1", mem_req, mem_addr, miss_cnt);
    end
    mem_serve(32'h40, 0, 0, 32'h0, -1, -1);
    drive_hit(32'h44);
    drive_hit(32'h40);
    stall = 0;
    pc = 32'h0; exp_miss++;
    mem_serve(32'h0, 0, 0, 32'h0, -1, -1);
    checks++;
    if (stall !== 6) begin
      errors++; $display("FAIL post_reset_invalid got stall=%0d required 6", stall);
    end
    drive_hit(32'h0);
    reset = 1'b1;
    checks++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      errors++; $display("FAIL final_cnt got hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_stalled();
    test_redirect();
    test_flush();
    test_reset_midfill();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_hits got %0d unconsumed required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
